am2927_busctl: RTL and testbench

Round-robin bus transfer sequencer for a shared bus built from NPORT am2927 quad bus transceivers, one transceiver slice per port. Each port requests a transfer to a destination port. The block arbitrates between requesters and then steps the winner's and the destination's am2927 control pins through load, drive and latch. It sits beside the transceivers and owns every s / endr_ / be_ / rle_ / oe_ pin on the shared bus.

---
 rtl/am2927_busctl.sv | 154 +++++++++++++++
 tb/tb_am2927_busctl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am2927_busctl.sv
// am2927_busctl: round-robin transfer sequencer for a shared bus built from
// one am2927 quad bus transceiver slice per port. Arbitrates among requesters,
// then steps the source and destination slices through load, drive and latch.
//
// Ports:
//   cp     clock, rising edge
//   rst    synchronous reset, active-high
//   req    per-port transfer request (level)
//   dst    destination index of port i at dst[i*AW +: AW]
//   gnt    one-hot grant to the current source port
//   busy   high whenever the sequencer is not idle
//   done   one-cycle pulse when a transfer completes
//   err    one-cycle pulse when a self-transfer request is rejected
//   s      am2927 driver-input select per port (0 selects D)
//   endr_  am2927 driver register enable, active-low
//   be_    am2927 bus enable, active-low
//   rle_   am2927 receive latch enable, active-low (low = transparent)
//   oe_    am2927 Y output enable, active-low, held per port
module am2927_busctl #(
    parameter int unsigned AW = 2,
    localparam int unsigned NPORT = 2 ** AW
) (
    input  logic                  cp,
    input  logic                  rst,
    input  logic [NPORT-1:0]      req,
    input  logic [NPORT*AW-1:0]   dst,
    output logic [NPORT-1:0]      gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [NPORT-1:0]      s,
    output logic [NPORT-1:0]      endr_,
    output logic [NPORT-1:0]      be_,
    output logic [NPORT-1:0]      rle_,
    output logic [NPORT-1:0]      oe_
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRIVE = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   src;
    logic [AW-1:0]   dsti;

    logic [AW-1:0]   win_c;
    logic [AW-1:0]   win_dst_c;
    logic [AW-1:0]   idx_c;
    logic            found_c;

    // Round-robin pick: first requesting port at or after ptr, wrapping.
    always_comb begin
        win_c   = '0;
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            idx_c = ptr + AW'(i);
            if (!found_c && req[idx_c]) begin
                win_c   = idx_c;
                found_c = 1'b1;
            end
        end
    end

    assign win_dst_c = dst[32'(win_c) * AW +: AW];

    // Sequencer. Outputs are registered for the state being entered, so each
    // pin pattern is visible for exactly the cycle its state occupies.
    always_ff @(posedge cp) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            src   <= '0;
            dsti  <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            s     <= '0;
            endr_ <= '1;
            be_   <= '1;
            rle_  <= '1;
            oe_   <= '1;
        end else begin
            gnt   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            s     <= '0;
            endr_ <= '1;
            be_   <= '1;
            rle_  <= '1;
            busy  <= 1'b1;
            case (state)
                IDLE: begin
                    if (found_c) begin
                        src  <= win_c;
                        dsti <= win_dst_c;
                        if (win_dst_c == win_c) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            state        <= LOAD;
                            gnt[win_c]   <= 1'b1;
                            endr_[win_c] <= 1'b0;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    // Driver register has captured D; source stops driving Y.
                    state      <= DRIVE;
                    gnt[src]   <= 1'b1;
                    be_[src]   <= 1'b0;
                    rle_[dsti] <= 1'b0;
                    oe_[src]   <= 1'b1;
                end
                DRIVE: begin
                    // Close the latch while the bus is still driven.
                    state    <= LATCH;
                    gnt[src] <= 1'b1;
                    be_[src] <= 1'b0;
                end
                LATCH: begin
                    state    <= DONE;
                    gnt[src] <= 1'b1;
                    done     <= 1'b1;
                end
                DONE: begin
                    state      <= IDLE;
                    oe_[dsti]  <= 1'b0;
                    ptr        <= src + AW'(1);
                    busy       <= 1'b0;
                end
                ERR: begin
                    state <= IDLE;
                    ptr   <= src + AW'(1);
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am2927_busctl.sv
// Testbench for am2927_busctl (AW=2, four ports). Stimulus pushes the
// hand-computed pin pattern of each expected transfer into a queue; a monitor
// pops an entry when the DUT starts a transfer or flags an error and follows
// the pin sequence through to completion.
module tb_am2927_busctl;

    logic       cp;
    logic       rst;
    logic [3:0] req;
    logic [7:0] dst;
    logic [3:0] gnt;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] s;
    logic [3:0] endr_;
    logic [3:0] be_;
    logic [3:0] rle_;
    logic [3:0] oe_;

    am2927_busctl #(.AW(2)) dut (
        .cp    (cp),
        .rst   (rst),
        .req   (req),
        .dst   (dst),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .s     (s),
        .endr_ (endr_),
        .be_   (be_),
        .rle_  (rle_),
        .oe_   (oe_)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    typedef struct {
        logic       is_err;
        logic [3:0] gnt;
        logic [3:0] endr;
        logic [3:0] be;
        logic [3:0] rle;
        logic [3:0] oe_mid;
        logic [3:0] oe_post;
        int         gap;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic xfer_t mk(input logic e, input logic [3:0] g, input logic [3:0] en,
                                 input logic [3:0] b, input logic [3:0] r,
                                 input logic [3:0] om, input logic [3:0] op, input int gp);
        xfer_t x;
        x.is_err  = e;
        x.gnt     = g;
        x.endr    = en;
        x.be      = b;
        x.rle     = r;
        x.oe_mid  = om;
        x.oe_post = op;
        x.gap     = gp;
        return x;
    endfunction

    // Monitor: invariants every cycle plus the per-transfer pin sequence.
    initial begin
        xfer_t cur;
        int    phase;
        int    cyc;
        int    last_done;
        phase     = 0;
        cyc       = 0;
        last_done = 0;
        forever begin
            @(negedge cp);
            cyc++;
            if (rst) begin
                phase = 0;
                exp_q.delete();
            end else begin
                chk("be_single_low", 32'($countones(~be_) <= 1), 1);
                chk("rle_single_low", 32'($countones(~rle_) <= 1), 1);
                chk("gnt_onehot0", 32'($countones(gnt) <= 1), 1);
                case (phase)
                    0: begin
                        if (err || endr_ != 4'hF) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_activity", 0, 1);
                            end else begin
                                cur = exp_q.pop_front();
                                chk("kind_err", err, cur.is_err);
                                if (err) begin
                                    chk("err_gnt", gnt, 0);
                                    chk("err_be", be_, 4'hF);
                                    chk("err_rle", rle_, 4'hF);
                                    chk("err_endr", endr_, 4'hF);
                                    chk("err_done", done, 0);
                                    phase = 5;
                                end else begin
                                    chk("load_endr", endr_, cur.endr);
                                    chk("load_s", s, 0);
                                    chk("load_gnt", gnt, cur.gnt);
                                    chk("load_be", be_, 4'hF);
                                    phase = 1;
                                end
                            end
                        end
                    end
                    1: begin
                        chk("drive_gnt", gnt, cur.gnt);
                        chk("drive_be", be_, cur.be);
                        chk("drive_rle", rle_, cur.rle);
                        chk("drive_oe", oe_, cur.oe_mid);
                        chk("drive_done", done, 0);
                        phase = 2;
                    end
                    2: begin
                        chk("latch_gnt", gnt, cur.gnt);
                        chk("latch_be", be_, cur.be);
                        chk("latch_rle", rle_, 4'hF);
                        chk("latch_done", done, 0);
                        phase = 3;
                    end
                    3: begin
                        chk("done_pulse", done, 1);
                        chk("done_gnt", gnt, cur.gnt);
                        chk("done_be", be_, 4'hF);
                        if (cur.gap != 0) chk("done_gap", 32'(cyc - last_done), 32'(cur.gap));
                        last_done = cyc;
                        phase = 4;
                    end
                    4: begin
                        chk("post_oe", oe_, cur.oe_post);
                        chk("post_done", done, 0);
                        chk("post_busy", busy, 0);
                        phase = 0;
                    end
                    default: begin
                        chk("err_one_cycle", err, 0);
                        chk("err_no_done", done, 0);
                        phase = 0;
                    end
                endcase
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge cp);
            n++;
        end while (busy && n < 40);
        chk("idle_timeout", busy, 0);
    endtask

    // Request, hold through LOAD, drop during DRIVE, wait for completion.
    task automatic run_xfer(input logic [3:0] rv, input logic [7:0] dv);
        @(posedge cp); #1;
        req = rv;
        dst = dv;
        repeat (2) @(posedge cp);
        #1 req = 4'b0000;
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge cp); #1;
        rst = 1'b1;
        req = 4'b0000;
        @(posedge cp); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        dst = 8'h39;
        repeat (2) @(posedge cp);
        @(negedge cp);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_s", s, 0);
        chk("rst_endr", endr_, 4'hF);
        chk("rst_be", be_, 4'hF);
        chk("rst_rle", rle_, 4'hF);
        chk("rst_oe", oe_, 4'hF);
        @(posedge cp); #1;
        req = 4'b0000;
        rst = 1'b0;

        // Port 1 to port 3; done expected in the 4th cycle after sampling.
        exp_q.push_back(mk(0, 4'b0010, 4'b1101, 4'b1101, 4'b0111, 4'b1111, 4'b0111, 0));
        @(posedge cp); #1;
        req = 4'b0010;
        dst = 8'h0C;
        repeat (2) @(posedge cp);
        #1 req = 4'b0000;
        @(posedge cp);
        @(posedge cp);
        @(negedge cp);
        chk("done_4th_cycle", done, 1);
        wait_idle();

        // Round robin from ptr=0, all ports requesting dst=(i+1)%4.
        do_reset();
        exp_q.push_back(mk(0, 4'b0001, 4'b1110, 4'b1110, 4'b1101, 4'b1111, 4'b1101, 0));
        exp_q.push_back(mk(0, 4'b0010, 4'b1101, 4'b1101, 4'b1011, 4'b1111, 4'b1011, 5));
        exp_q.push_back(mk(0, 4'b0100, 4'b1011, 4'b1011, 4'b0111, 4'b1111, 4'b0111, 5));
        exp_q.push_back(mk(0, 4'b1000, 4'b0111, 4'b0111, 4'b1110, 4'b1111, 4'b1110, 5));
        exp_q.push_back(mk(0, 4'b0001, 4'b1110, 4'b1110, 4'b1101, 4'b1111, 4'b1101, 5));
        @(posedge cp); #1;
        req = 4'b1111;
        dst = 8'h39;
        repeat (22) @(posedge cp);
        #1 req = 4'b0000;
        wait_idle();

        // ptr=1: port 2 self-transfer rejected, then port 3 beats port 0.
        exp_q.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b1101, 0));
        exp_q.push_back(mk(0, 4'b1000, 4'b0111, 4'b0111, 4'b1110, 4'b1101, 4'b1100, 0));
        exp_q.push_back(mk(0, 4'b0001, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101, 0));
        @(posedge cp); #1;
        req = 4'b1101;
        dst = 8'b00_10_00_01;
        @(posedge cp); #1;
        req = 4'b1001;
        repeat (3) @(posedge cp);
        #1 req = 4'b0001;
        repeat (5) @(posedge cp);
        #1 req = 4'b0000;
        wait_idle();

        // Reset asserted during DRIVE releases the bus at the next edge.
        exp_q.push_back(mk(0, 4'b0010, 4'b1101, 4'b1101, 4'b0111, 4'b1111, 4'b0111, 0));
        @(posedge cp); #1;
        req = 4'b0010;
        dst = 8'h0C;
        repeat (2) @(posedge cp);
        #1;
        rst = 1'b1;
        req = 4'b0000;
        @(posedge cp);
        @(negedge cp);
        chk("mid_rst_be", be_, 4'hF);
        chk("mid_rst_rle", rle_, 4'hF);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_oe", oe_, 4'hF);
        @(posedge cp); #1;
        rst = 1'b0;

        // oe_ tracking: 0 to 2, then 2 to 1.
        exp_q.push_back(mk(0, 4'b0001, 4'b1110, 4'b1110, 4'b1011, 4'b1111, 4'b1011, 0));
        run_xfer(4'b0001, 8'h02);
        exp_q.push_back(mk(0, 4'b0100, 4'b1011, 4'b1011, 4'b1101, 4'b1111, 4'b1101, 0));
        run_xfer(4'b0100, 8'h10);

        repeat (3) @(negedge cp);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
